// File: rtl/cpu_pkg.sv
// Shared types for the MEM/WB stage.
//   alu_op_t      : ALUOp encoding seen by the stage
//   stage_state_t : stage FSM states
//   MEM_LAT_MAX   : largest supported data-memory read latency
package cpu_pkg;
  typedef enum logic [2:0] {
    OP_LD, OP_SHR, OP_ADD, OP_POS, OP_XOR, OP_BEQ, OP_LW, OP_SW
  } alu_op_t;

  typedef enum logic {IDLE, RD_WAIT} stage_state_t;

  localparam int MEM_LAT_MAX = 3;
endpackage

// File: rtl/mem_wb_stage_if.sv
// ALU -> MEM/WB handshake bundle.
//   master : upstream (ALU) side, drives in_valid and the ALU outputs, sees in_ready
//   slave  : MEM/WB stage side
//   in_valid, in_ready, alu_op, rslt, carry_out, taken, dest_reg, store_data, br_target_in
interface mem_wb_stage_if #(
  parameter int RA_W = 3,
  parameter int PC_W = 10
);
  import cpu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  alu_op_t         alu_op;
  logic [7:0]      rslt;
  logic            carry_out;
  logic            taken;
  logic [RA_W-1:0] dest_reg;
  logic [7:0]      store_data;
  logic [PC_W-1:0] br_target_in;

  modport master (
    output in_valid, alu_op, rslt, carry_out, taken, dest_reg, store_data, br_target_in,
    input  in_ready
  );

  modport slave (
    input  in_valid, alu_op, rslt, carry_out, taken, dest_reg, store_data, br_target_in,
    output in_ready
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: registers ALU results, performs lw/sw data-memory access,
// writes the register file, keeps the carry flag and issues branch redirects.
// Every output is registered; a transfer is seen on the outputs one cycle later.
// lw holds the stage in RD_WAIT (in_ready=0) until read data arrives.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   up (slave)      : ALU handshake + operands
//   carry_clr       : synchronous clear of carry_flag (wins over add/xor)
//   carry_flag      : registered carry, feeds ALU carry_in
//   dmem_*          : data-memory address / strobes / data
//   rf_we/waddr/wdata : register-file write port
//   br_taken/br_target: one-cycle redirect
//   zero_flag       : present only when ZERO_FLAG_EN is defined
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int RA_W    = 3,
  parameter int PC_W    = 10,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  mem_wb_stage_if.slave   up,
  input  logic            carry_clr,
  output logic            carry_flag,
  output logic [7:0]      dmem_addr,
  output logic            dmem_rd_en,
  output logic            dmem_wr_en,
  output logic [7:0]      dmem_wr_data,
  input  logic [7:0]      dmem_rd_data,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [7:0]      rf_wdata,
  output logic            br_taken,
`ifdef ZERO_FLAG_EN
  output logic            zero_flag,
`endif
  output logic [PC_W-1:0] br_target
);
  // Out-of-range latencies are clamped into the supported 1..MEM_LAT_MAX window.
  localparam int LAT = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : ((MEM_LAT < 1) ? 1 : MEM_LAT);

  stage_state_t    state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [RA_W-1:0] lw_dest_q, lw_dest_d;
  logic            rdy_q, rdy_d;
  logic            carry_d, rf_we_d, rd_en_d, wr_en_d, br_taken_d;
  logic [RA_W-1:0] rf_waddr_d;
  logic [7:0]      rf_wdata_d, addr_d, wr_data_d;
  logic [PC_W-1:0] br_target_d;
  logic            accept;
`ifdef ZERO_FLAG_EN
  logic            zero_d;
`endif

  // in_ready is only ever 1 in IDLE, so this also implies state_q == IDLE.
  assign accept      = up.in_valid && rdy_q;
  assign up.in_ready = rdy_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lw_dest_d   = lw_dest_q;
    carry_d     = carry_flag;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr;
    rf_wdata_d  = rf_wdata;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    addr_d      = dmem_addr;
    wr_data_d   = dmem_wr_data;
    br_taken_d  = 1'b0;
    br_target_d = br_target;
`ifdef ZERO_FLAG_EN
    zero_d      = zero_flag;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (up.alu_op)
            OP_LD, OP_SHR: begin
              rf_we_d    = 1'b1;
              rf_waddr_d = up.dest_reg;
              rf_wdata_d = up.rslt;
            end
            OP_ADD, OP_XOR: begin
              rf_we_d    = 1'b1;
              rf_waddr_d = up.dest_reg;
              rf_wdata_d = up.rslt;
              carry_d    = up.carry_out;
`ifdef ZERO_FLAG_EN
              zero_d     = (up.rslt == 8'h00);
`endif
            end
            OP_POS, OP_BEQ: begin
              br_taken_d  = up.taken;
              br_target_d = up.br_target_in;
            end
            OP_LW: begin
              rd_en_d   = 1'b1;
              addr_d    = up.rslt;
              lw_dest_d = up.dest_reg;
              cnt_d     = 2'd0;
              state_d   = RD_WAIT;
            end
            default: begin  // OP_SW
              wr_en_d   = 1'b1;
              addr_d    = up.rslt;
              wr_data_d = up.store_data;
            end
          endcase
        end
      end
      default: begin  // RD_WAIT
        // cnt_q==0 is the rd_en cycle; read data is on the bus when cnt_q reaches LAT.
        if (cnt_q == 2'(LAT)) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = lw_dest_q;
          rf_wdata_d = dmem_rd_data;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
    endcase
    if (carry_clr) begin
      carry_d = 1'b0;
`ifdef ZERO_FLAG_EN
      zero_d  = 1'b0;
`endif
    end
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lw_dest_q    <= '0;
      rdy_q        <= 1'b0;
      carry_flag   <= 1'b0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      dmem_rd_en   <= 1'b0;
      dmem_wr_en   <= 1'b0;
      dmem_addr    <= '0;
      dmem_wr_data <= '0;
      br_taken     <= 1'b0;
      br_target    <= '0;
`ifdef ZERO_FLAG_EN
      zero_flag    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lw_dest_q    <= lw_dest_d;
      rdy_q        <= rdy_d;
      carry_flag   <= carry_d;
      rf_we        <= rf_we_d;
      rf_waddr     <= rf_waddr_d;
      rf_wdata     <= rf_wdata_d;
      dmem_rd_en   <= rd_en_d;
      dmem_wr_en   <= wr_en_d;
      dmem_addr    <= addr_d;
      dmem_wr_data <= wr_data_d;
      br_taken     <= br_taken_d;
      br_target    <= br_target_d;
`ifdef ZERO_FLAG_EN
      zero_flag    <= zero_d;
`endif
    end
  end
endmodule
